// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic-BIST sequencer for an LFSR pattern generator (rpg), the CUT and a
// response MISR. A start request resets rpg and the MISR, applies PATTERNS patterns,
// flushes the CUT pipeline for FLUSH_CYC cycles, then compares the MISR signature with
// GOLDEN. It also checks that rpg_end arrives exactly at RUN cycle END_AT.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   start      launches a test from IDLE or DONE
//   abort      returns to IDLE from any state (wins over start)
//   rpg_end    end-of-cycle pulse from rpg
//   signature  current MISR contents
//   rpg_rst    holds rpg at its seed while high
//   misr_rst   synchronous clear to the MISR
//   misr_en    MISR capture enable
//   test_mode  routes LFSR patterns into the CUT
//   busy       high in INIT/RUN/FLUSH/CMP
//   done       high in DONE
//   pass       result, valid while done
//   seq_err    rpg_end timing fault, valid while done
//   pat_cnt    patterns applied so far (saturating)
module lbist_ctrl #(
    parameter int unsigned          BITS      = 4,
    parameter int unsigned          SIG_BITS  = 4,
    parameter int unsigned          PATTERNS  = (1 << BITS) - 1,
    parameter int unsigned          FLUSH_CYC = 2,
    parameter int unsigned          END_AT    = 1,
    parameter logic [SIG_BITS-1:0]  GOLDEN    = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              rpg_end,
    input  logic [SIG_BITS-1:0]               signature,
    output logic                              rpg_rst,
    output logic                              misr_rst,
    output logic                              misr_en,
    output logic                              test_mode,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              seq_err,
    output logic [$clog2(PATTERNS+1)-1:0]     pat_cnt
);

    localparam int unsigned PW     = $clog2(PATTERNS + 1);
    localparam int unsigned CntMax = (PATTERNS > FLUSH_CYC) ? PATTERNS : FLUSH_CYC;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] RunLast   = CW'(PATTERNS - 1);
    localparam logic [CW-1:0] FlushLast = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] EndAt     = CW'(END_AT);
    localparam logic [PW-1:0] PatMax    = PW'(PATTERNS);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StInit  = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StCmp   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pat_cnt_q, pat_cnt_d;
    logic          end_seen_q, end_seen_d;
    logic          seq_err_q, seq_err_d;
    logic          pass_q, pass_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_cnt_d  = pat_cnt_q;
        end_seen_d = end_seen_q;
        seq_err_d  = seq_err_q;
        pass_d     = pass_q;

        if (abort) begin
            state_d   = StIdle;
            pass_d    = 1'b0;
            seq_err_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) state_d = StInit;
                end
                StInit: begin
                    cnt_d      = '0;
                    pat_cnt_d  = '0;
                    end_seen_d = 1'b0;
                    seq_err_d  = 1'b0;
                    pass_d     = 1'b0;
                    state_d    = StRun;
                end
                StRun: begin
                    cnt_d = cnt_q + 1'b1;
                    if (pat_cnt_q != PatMax) pat_cnt_d = pat_cnt_q + 1'b1;
                    if (rpg_end) begin
                        if (cnt_q == EndAt) end_seen_d = 1'b1;
                        else                seq_err_d  = 1'b1;
                    end
                    if (cnt_q == RunLast) begin
                        cnt_d   = '0;  // reused as the flush counter
                        state_d = StFlush;
                    end
                end
                StFlush: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == FlushLast) begin
                        cnt_d   = '0;
                        state_d = StCmp;
                    end
                end
                StCmp: begin
                    // a missing end pulse is a sequencing fault too
                    seq_err_d = seq_err_q | ~end_seen_q;
                    pass_d    = (signature == GOLDEN) && !seq_err_d;
                    state_d   = StDone;
                end
                StDone: begin
                    if (start) state_d = StInit;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pat_cnt_q  <= '0;
            end_seen_q <= 1'b0;
            seq_err_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            end_seen_q <= end_seen_d;
            seq_err_q  <= seq_err_d;
            pass_q     <= pass_d;
        end
    end

    // Outputs decode only registered state, so rst reaches them without a clock.
    always_comb begin
        rpg_rst   = (state_q == StIdle) || (state_q == StInit) ||
                    (state_q == StCmp)  || (state_q == StDone);
        misr_rst  = (state_q == StIdle) || (state_q == StInit);
        misr_en   = (state_q == StRun)  || (state_q == StFlush);
        test_mode = (state_q == StRun)  || (state_q == StFlush);
        busy      = (state_q == StInit) || (state_q == StRun) ||
                    (state_q == StFlush) || (state_q == StCmp);
        done      = (state_q == StDone);
        pass      = pass_q;
        seq_err   = seq_err_q;
        pat_cnt   = pat_cnt_q;
    end

endmodule

// File: tb/tb_lbist_ctrl.sv
module tb_lbist_ctrl;

    localparam int unsigned BITS      = 4;
    localparam int unsigned SIG_BITS  = 4;
    localparam int unsigned PATTERNS  = 15;
    localparam int unsigned FLUSH_CYC = 2;
    localparam int unsigned END_AT    = 1;
    localparam logic [3:0]  GOLDEN    = 4'h0;
    localparam int unsigned DONE_LAT  = PATTERNS + FLUSH_CYC + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, rpg_end;
    logic [3:0] signature;
    logic       rpg_rst, misr_rst, misr_en, test_mode, busy, done, pass, seq_err;
    logic [3:0] pat_cnt;

    int checks = 0;
    int errors = 0;

    lbist_ctrl #(
        .BITS      (BITS),
        .SIG_BITS  (SIG_BITS),
        .PATTERNS  (PATTERNS),
        .FLUSH_CYC (FLUSH_CYC),
        .END_AT    (END_AT),
        .GOLDEN    (GOLDEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rpg_end   (rpg_end),
        .signature (signature),
        .rpg_rst   (rpg_rst),
        .misr_rst  (misr_rst),
        .misr_en   (misr_en),
        .test_mode (test_mode),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .seq_err   (seq_err),
        .pat_cnt   (pat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rpg_rst"},  32'(rpg_rst),  1);
        check({tag, "_misr_rst"}, 32'(misr_rst), 1);
        check({tag, "_misr_en"},  32'(misr_en),  0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_done"},     32'(done),     0);
        check({tag, "_pass"},     32'(pass),     0);
        check({tag, "_seq_err"},  32'(seq_err),  0);
    endtask

    // One full test launched from IDLE or DONE. pulses[i] drives rpg_end at RUN cycle i.
    task automatic do_run(input logic [14:0] pulses, input logic [3:0] sig, input bit glitch);
        int   men, bsy, dn;
        logic exp_seq, exp_pass;
        logic [14:0] others;
        others   = pulses & ~(15'(1) << END_AT);
        exp_seq  = (others != 15'd0) || !pulses[END_AT];
        exp_pass = (sig == GOLDEN) && !exp_seq;
        men = 0; bsy = 0; dn = 0;

        start = 1'b1;
        tick();  // E0
        start = 1'b0;
        check("init_busy", 32'(busy), 1);
        check("init_rpg_rst", 32'(rpg_rst), 1);
        bsy += int'(busy); men += int'(misr_en); dn += int'(done);
        tick();  // E1
        check("run_rpg_rst", 32'(rpg_rst), 0);
        check("run_test_mode", 32'(test_mode), 1);
        check("run_pat_cnt0", 32'(pat_cnt), 0);
        check("run_pass_clr", 32'(pass), 0);
        for (int i = 0; i < int'(PATTERNS); i++) begin
            bsy += int'(busy); men += int'(misr_en); dn += int'(done);
            rpg_end   = pulses[i];
            signature = 4'($urandom);
            start     = glitch && (i == 4);
            tick();
        end
        rpg_end = 1'b0;
        start   = 1'b0;
        for (int f = 0; f < int'(FLUSH_CYC); f++) begin
            bsy += int'(busy); men += int'(misr_en); dn += int'(done);
            rpg_end = 1'($urandom_range(0, 1));
            tick();
        end
        bsy += int'(busy); men += int'(misr_en); dn += int'(done);
        rpg_end   = 1'b0;
        signature = sig;
        tick();  // E(DONE_LAT)
        check("done", 32'(done), 1);
        check("pass", 32'(pass), 32'(exp_pass));
        check("seq_err", 32'(seq_err), 32'(exp_seq));
        check("pat_cnt", 32'(pat_cnt), PATTERNS);
        check("done_busy", 32'(busy), 0);
        check("done_rpg_rst", 32'(rpg_rst), 1);
        check("misr_en_cycles", 32'(men), PATTERNS + FLUSH_CYC);
        check("busy_cycles", 32'(bsy), DONE_LAT);
        check("early_done", 32'(dn), 0);
        signature = 4'($urandom);
        tick();
        check("done_hold", 32'(done), 1);
        check("pass_hold", 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; rpg_end = 1'b0; signature = 4'h0;
        #12;
        check_idle("rst");
        check("rst_pat_cnt", 32'(pat_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("idle");

        do_run(15'b10, GOLDEN, 1'b0);
        do_run(15'b10, GOLDEN ^ 4'h1, 1'b0);
        do_run(15'b10 | (15'(1) << 7), GOLDEN, 1'b0);
        do_run(15'b0, GOLDEN, 1'b0);

        // abort at RUN cnt=5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        tick();
        check("abort_stay_idle", 32'(busy), 0);
        do_run(15'b10, GOLDEN, 1'b0);

        // start glitch during RUN is ignored
        do_run(15'b10, GOLDEN, 1'b1);

        // start+abort together in DONE -> IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_idle("st_ab");
        tick();
        check("st_ab_stay", 32'(busy), 0);

        // async reset in FLUSH
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(PATTERNS) + 1; i++) tick();
        check("flush_test_mode", 32'(test_mode), 1);
        check("flush_rpg_rst", 32'(rpg_rst), 0);
        #2 rst = 1'b1;
        #1;
        check_idle("arst");
        check("arst_test_mode", 32'(test_mode), 0);
        check("arst_pat_cnt", 32'(pat_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back runs: second start issued straight from DONE
        do_run(15'b10, GOLDEN, 1'b0);
        do_run(15'b10 | 15'b1, GOLDEN, 1'b0);
        do_run(15'b10, GOLDEN, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [14:0] p;
            logic [3:0]  s;
            case ($urandom_range(0, 3))
                0, 1:    p = 15'b10;
                2:       p = 15'($urandom);
                default: p = 15'b10 ^ (15'(1) << $urandom_range(0, 14));
            endcase
            s = ($urandom_range(0, 1) == 0) ? GOLDEN : 4'($urandom);
            do_run(p, s, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbist_ctrl.md
# lbist_ctrl

Logic-BIST sequencer for the LFSR pattern generator (`rpg`), the circuit under test and the response MISR. On a `start` request it resets the generator and the MISR, runs the test for a fixed number of pattern cycles, and flushes the CUT pipeline into the MISR. It then compares the final signature against a golden value and reports pass/fail. It also checks that the generator's end-of-cycle pulse arrives exactly when the pattern count says it should.

## Interface
- `BITS`, 4, LFSR width of the driven `rpg`.
- `SIG_BITS`, 4, MISR signature width.
- `PATTERNS`, (1<<BITS)-1, number of RUN cycles (patterns applied).
- `FLUSH_CYC`, 2, CUT-to-MISR latency cycles appended after RUN (≥1).
- `END_AT`, 1, RUN cycle index at which `rpg_end` must be seen.
- `GOLDEN`, 0, expected signature (SIG_BITS wide).

Ports:
- `clk`  in  1  clock, all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled each posedge; a high sample launches a test from IDLE or DONE.
- `abort`  in  1  sampled each posedge; returns to IDLE from any state.
- `rpg_end`  in  1  END pulse from `rpg`.
- `signature`  in  SIG_BITS  current MISR contents.
- `rpg_rst`  out  1  drives `rpg` reset; high holds the LFSR at its seed.
- `misr_rst`  out  1  synchronous clear to the MISR.
- `misr_en`  out  1  MISR capture enable.
- `test_mode`  out  1  selects LFSR patterns into the CUT inputs.
- `busy`  out  1  high in INIT/RUN/FLUSH/CMP.
- `done`  out  1  high in DONE.
- `pass`  out  1  result, valid while `done`.
- `seq_err`  out  1  `rpg_end` timing fault, valid while `done`.
- `pat_cnt`  out  $clog2(PATTERNS+1)  patterns applied so far.

## Operation
- All outputs are registered and decoded from the state register. Reset values: `rpg_rst`=1, `misr_rst`=1, `misr_en`=0, `test_mode`=0, `busy`=0, `done`=0, `pass`=0, `seq_err`=0, `pat_cnt`=0, state IDLE.
- IDLE: `rpg_rst`=1, `misr_rst`=1, everything else 0. `start`=1 moves to INIT.
- INIT (1 cycle): `rpg_rst`=1, `misr_rst`=1, `busy`=1. Clears `pat_cnt`, `seq_err`, `pass`, and the internal end-seen flag. Moves to RUN.
- RUN (PATTERNS cycles): `rpg_rst`=0, `misr_rst`=0, `misr_en`=1, `test_mode`=1. The internal counter `cnt` runs 0..PATTERNS-1 and increments every cycle; `pat_cnt` = `cnt`+1 registered.
  - `rpg_end` high when `cnt`==END_AT sets end-seen.
  - `rpg_end` high at any other `cnt` sets `seq_err`.
  - When `cnt`==PATTERNS-1, moves to FLUSH.
- FLUSH (FLUSH_CYC cycles): `rpg_rst`=0, `misr_en`=1, `test_mode`=1. `rpg_end` is ignored. Then moves to CMP.
- CMP (1 cycle): `misr_en`=0, `test_mode`=0.
  - If end-seen is still 0, sets `seq_err`.
  - Registers `pass` = (`signature`==GOLDEN) && !`seq_err`_next.
  - Moves to DONE.
- DONE: `done`=1, `rpg_rst`=1. Holds `pass`, `seq_err` and `pat_cnt` stable until `start` (goes to INIT) or `abort` (goes to IDLE).
- `start` in INIT/RUN/FLUSH/CMP is ignored.
- `abort` in any state moves to IDLE at the next edge and clears `done`, `pass` and `seq_err`. When `abort` and `start` are high in the same cycle, `abort` wins.
- `rst` mid-test forces all reset values immediately, with no handshake.
- `pat_cnt` saturates at PATTERNS.

## Timing
- Let E0 be the edge that samples `start` in IDLE. The state is INIT after E0, RUN after E1, FLUSH after E(PATTERNS+1), CMP after E(PATTERNS+FLUSH_CYC+1), and DONE after E(PATTERNS+FLUSH_CYC+2).
- For the defaults (PATTERNS=15, FLUSH_CYC=2), `done` first becomes high after E19, and `busy` is high from after E0 through E18.
- `rpg_rst` falls after E1 and rises after E(PATTERNS+FLUSH_CYC+1).
- `misr_en` is high for exactly PATTERNS+FLUSH_CYC cycles.
- `signature` is sampled on the edge that leaves CMP, i.e. one cycle after the last `misr_en` cycle.
- A restart from DONE has the same latency as a start from IDLE.

## Test plan
- Defaults, correct `rpg_end` at `cnt`=1, `signature`=GOLDEN at CMP -> `done` high after E19, `pass`=1, `seq_err`=0, `pat_cnt`=15, `misr_en` high for 17 cycles.
- Same run with `signature`=GOLDEN^1 -> `done`=1, `pass`=0, `seq_err`=0.
- `rpg_end` additionally pulsed at `cnt`=7 -> `seq_err`=1, `pass`=0 even with a matching signature. A second run with `rpg_end` never asserted -> `seq_err`=1.
- `abort` at RUN `cnt`=5 -> IDLE next edge, `rpg_rst`=1, `busy`=0, `done`=0. A later `start` completes normally in 19 edges.
- `start` pulsed during RUN -> no effect, `done` still after E19. `start`+`abort` together in DONE -> IDLE.
- `rst` asserted asynchronously mid-FLUSH -> all outputs reach their reset values before the next clock edge. Back-to-back `start` held high in DONE -> INIT immediately and a full second run, `pass` cleared during the run.
